// File: rtl/spcpu_prefetch_unit.sv
// spcpu_prefetch_unit: halfword prefetch queue that assembles 16/32-bit instructions for the core
// and flushes on redirect, discarding any stale in-flight fetch.
module spcpu_prefetch_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int HALF_WIDTH = 16,
    parameter int QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter logic [HALF_WIDTH-1:0] IG5_MASK = 16'hc000,
    parameter logic [HALF_WIDTH-1:0] IG5_MATCH = 16'hc000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [HALF_WIDTH-1:0] mem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_take,
    output logic [HALF_WIDTH-1:0] instr_hi,
    output logic [HALF_WIDTH-1:0] instr_lo,
    output logic                  instr_is_32,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  misaligned
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DEPTH);

    typedef enum logic {F_IDLE, F_WAIT} fstate_t;

    fstate_t state, state_next;
    logic [HALF_WIDTH-1:0] q [QUEUE_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_next;
    logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_next, decode_pc, redirect_pc, addr_next;
    logic discard, ack, push, head_32, issue, req_next;
    logic [1:0] pop;

    assign redirect_pc = {redirect_addr[ADDR_WIDTH-1:1], 1'b0};
    assign ack = mem_ack && state == F_WAIT;
    // A redirect drops whatever arrives in the same cycle along with the queue.
    assign push = ack && !discard && !redirect_valid;
    assign head_32 = (q[head] & IG5_MASK) == IG5_MATCH;
    assign instr_valid = (count >= CW'(1) && !head_32) || count >= CW'(2);
    assign pop = (instr_take && instr_valid && !redirect_valid) ? (head_32 ? 2'd2 : 2'd1) : 2'd0;
    assign count_next = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    assign fetch_pc_next = redirect_valid ? redirect_pc : push ? fetch_pc + ADDR_WIDTH'(2) : fetch_pc;
    assign instr_hi = instr_valid ? q[head] : '0;
    assign instr_is_32 = instr_valid && head_32;
    assign instr_lo = instr_is_32 ? q[head + PW'(1)] : '0;
    assign instr_pc = decode_pc;

    // Issuing against count_next keeps count + outstanding within the queue depth.
    always_comb begin
        state_next = state;
        req_next = mem_req;
        addr_next = mem_addr;
        issue = count_next < DEPTH;
        if (state == F_IDLE || ack) begin
            state_next = issue ? F_WAIT : F_IDLE;
            req_next = issue;
            addr_next = issue ? fetch_pc_next : mem_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= F_IDLE;
            mem_req <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
            decode_pc <= RESET_PC;
            count <= '0;
            head <= '0;
            tail <= '0;
            discard <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state <= state_next;
            mem_req <= req_next;
            mem_addr <= addr_next;
            fetch_pc <= fetch_pc_next;
            count <= count_next;
            decode_pc <= redirect_valid ? redirect_pc : decode_pc + ADDR_WIDTH'({pop, 1'b0});
            head <= redirect_valid ? '0 : head + PW'(pop);
            tail <= redirect_valid ? '0 : tail + PW'(push);
            discard <= (redirect_valid && state == F_WAIT && !mem_ack) ? 1'b1 : ack ? 1'b0 : discard;
            misaligned <= redirect_valid && redirect_addr[0];
        end
    end

    always_ff @(posedge clk) begin
        if (push) q[tail] <= mem_rdata;
    end
endmodule

// File: tb/tb_spcpu_prefetch_unit.sv
// tb_spcpu_prefetch_unit: directed and random stimulus against a PC-level model of the
// instruction stream, fetch address sequence and queue occupancy.
module tb_spcpu_prefetch_unit;
    logic clk = 1'b0;
    logic reset;
    logic mem_req, mem_ack, instr_valid, instr_take, instr_is_32, redirect_valid, misaligned;
    logic [15:0] mem_addr, mem_rdata, instr_hi, instr_lo, instr_pc, redirect_addr;

    spcpu_prefetch_unit dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_take(instr_take),
        .instr_hi(instr_hi), .instr_lo(instr_lo), .instr_is_32(instr_is_32), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [1024];
    int vectors = 0;
    int miscompares = 0;
    logic [15:0] efa, epc, prev_addr;
    logic stale, prev_pending, exp_mis, ack_en, seen, r1;
    int dly, max_dly, nacks, retired;

    function automatic logic [15:0] memw(input logic [15:0] a);
        return mem[a[10:1]];
    endfunction

    function automatic logic is32f(input logic [15:0] h);
        return (h & 16'hc000) == 16'hc000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks();
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_hi", instr_hi, 0);
        chk("rst_lo", instr_lo, 0);
        chk("rst_is32", instr_is_32, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_mis", misaligned, 0);
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model, step past the edge.
    task automatic cycle(input logic tk, input logic rv, input logic [15:0] ra);
        logic [15:0] av, nxt;
        logic e32, ack;
        av = (efa - epc) >> 1;
        nxt = epc + 16'd2;
        e32 = is32f(memw(epc));
        chk("valid", instr_valid, (av >= 1 && !e32) || av >= 2);
        if (instr_valid) begin
            chk("pc", instr_pc, epc);
            chk("hi", instr_hi, memw(epc));
            chk("is32", instr_is_32, e32);
            chk("lo", instr_lo, e32 ? memw(nxt) : 16'h0);
        end
        chk("slots", (av + mem_req) <= 4, 1);
        chk("misaligned", misaligned, exp_mis);
        chk("addr_lsb", mem_addr[0], 0);
        if (prev_pending) begin
            chk("req_hold", mem_req, 1);
            chk("addr_hold", mem_addr, prev_addr);
        end
        ack = 1'b0;
        if (mem_req && ack_en) begin
            if (dly == 0) ack = 1'b1;
            else dly--;
        end
        instr_take = tk;
        redirect_valid = rv;
        redirect_addr = ra;
        mem_ack = ack;
        mem_rdata = ack ? memw(mem_addr) : 16'($urandom);
        if (ack) begin
            if (!stale && !rv) begin
                chk("fetch_addr", mem_addr, efa);
                efa = efa + 16'd2;
                nacks++;
            end
            stale = 1'b0;
            dly = $urandom_range(0, max_dly);
        end
        if (rv) begin
            efa = {ra[15:1], 1'b0};
            epc = efa;
            if (mem_req && !ack) stale = 1'b1;
        end else if (tk && instr_valid) begin
            epc = epc + (e32 ? 16'd4 : 16'd2);
            retired++;
        end
        exp_mis = rv && ra[0];
        prev_pending = mem_req && !ack;
        prev_addr = mem_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        efa = 16'h0;
        epc = 16'h0;
        stale = 1'b0;
        prev_pending = 1'b0;
        exp_mis = 1'b0;
        dly = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) mem[i] = 16'h0100 + 16'(i);
        mem[4] = 16'h0bad;
        mem[8] = 16'hc123;
        mem[9] = 16'h4567;
        mem[10] = 16'h1111;
        mem[16'h20] = 16'h0040;
        mem[16'h21] = 16'h0042;
        mem[16'h80] = 16'h0100;
        mem[16'h3fe] = 16'h0001;
        mem[16'h3ff] = 16'h0002;
        reset = 1'b0;
        {mem_ack, instr_take, redirect_valid} = '0;
        mem_rdata = '0;
        redirect_addr = '0;
        model_reset();
        ack_en = 1'b1;
        max_dly = 0;
        nacks = 0;
        retired = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        // zero-wait stream of 16-bit instructions from 0
        chk("t1_first_req", mem_addr, 0);
        repeat (12) cycle(1, 0, 0);
        chk("t1_progress", retired >= 6, 1);
        // 32-bit instruction at 0x10
        max_dly = 2;
        seen = 1'b0;
        cycle(0, 1, 16'h0010);
        for (int i = 0; i < 20; i++) begin
            if (instr_valid && instr_pc == 16'h0010 && !seen) begin
                chk("t2_is32", instr_is_32, 1);
                chk("t2_lo", instr_lo, 16'h4567);
                seen = 1'b1;
            end
            cycle(1, 0, 0);
        end
        chk("t2_seen", seen, 1);
        // queue fills with no takes, one take restarts fetch
        max_dly = 0;
        nacks = 0;
        cycle(0, 1, 16'h0100);
        repeat (10) cycle(0, 0, 0);
        chk("t3_acks", nacks, 4);
        chk("t3_req_idle", mem_req, 0);
        cycle(1, 0, 0);
        r1 = mem_req;
        cycle(0, 0, 0);
        chk("t3_restart", r1 | mem_req, 1);
        repeat (4) cycle(0, 0, 0);
        // redirect while a fetch to 0x08 is outstanding
        ack_en = 1'b0;
        cycle(0, 1, 16'h0008);
        chk("t4_req8", mem_addr, 16'h0008);
        cycle(0, 1, 16'h0040);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        dly = 0;
        ack_en = 1'b1;
        cycle(0, 0, 0);
        chk("t4_addr", mem_addr, 16'h0040);
        chk("t4_req", mem_req, 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (instr_valid && !seen) begin
                chk("t4_first_pc", instr_pc, 16'h0040);
                seen = 1'b1;
            end
            cycle(1, 0, 0);
        end
        // misaligned redirect and address wrap
        max_dly = 1;
        cycle(0, 1, 16'h0041);
        chk("t5_mis", misaligned, 1);
        repeat (6) cycle(1, 0, 0);
        cycle(0, 1, 16'hfffc);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req && mem_addr == 16'h0000) seen = 1'b1;
            cycle(1, 0, 0);
        end
        chk("t5_wrap", seen, 1);
        // random traffic
        max_dly = 3;
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, 16'($urandom));
        chk("rand_progress", retired > 300, 1);
        // async reset in the middle of an outstanding fetch
        ack_en = 1'b0;
        cycle(0, 1, 16'h0200);
        cycle(0, 0, 0);
        chk("t6_pending", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        reset_checks();
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'h1234;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk("t6_valid", instr_valid, 0);
        chk("t6_req", mem_req, 1);
        chk("t6_addr", mem_addr, 0);
        model_reset();
        ack_en = 1'b1;
        repeat (10) cycle(1, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
